ifu_fetch: RTL and testbench

//  Instruction fetch front end. Owns the PC and issues one word fetch at a time to the

---
 rtl/ifu_fetch_pkg.sv | 19 +
 rtl/ifu_fetch_if.sv | 29 ++
 rtl/ifu_fetch.sv | 109 ++++++++++
 tb/tb_ifu_fetch.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
// Every file that touches the fetch FSM imports this package.
package ifu_fetch_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_RESP = 2'd1,
    S_OUT  = 2'd2
  } ifu_state_e;

  localparam logic [31:0] IFU_RESET_PC = 32'h3000_0000;
  localparam logic [31:0] IFU_PC_STEP  = 32'd4;

  // A fetch may only go out on a word boundary.
  function automatic logic pc_aligned(input logic [1:0] pc_low);
    return pc_low == 2'b00;
  endfunction

endpackage

// File: rtl/ifu_fetch_if.sv
// Bundles the fetch unit's redirect, icache AR/R and decode handshakes.
// The fetch unit uses the master side; the icache, decode and branch logic use the slave side.
interface ifu_fetch_if;

  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        arvalid_o;
  logic [31:0] araddr_o;
  logic        arready_i;
  logic        rvalid_i;
  logic [31:0] rdata_i;
  logic        rready_o;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        err_o;

  modport master (
    input  redirect_i, redirect_pc_i, arready_i, rvalid_i, rdata_i, ready_i,
    output arvalid_o, araddr_o, rready_o, valid_o, pc_o, inst_o, err_o
  );

  modport slave (
    output redirect_i, redirect_pc_i, arready_i, rvalid_i, rdata_i, ready_i,
    input  arvalid_o, araddr_o, rready_o, valid_o, pc_o, inst_o, err_o
  );

endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch front end: owns the PC, issues one icache fetch at a time,
// and hands {pc, inst, err} to decode. A redirect squashes any wrong-path fetch.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IFU_RESET_PC
) (
  input  logic        clock,
  input  logic        reset,
  ifu_fetch_if.master bus
);

  ifu_state_e  state_q;
  logic [31:0] pc_q;
  logic [31:0] inst_q;
  logic        err_q;
  logic        flush_q;

  logic aligned;
  logic req_fire;
  logic beat_fire;
  logic out_fire;

  assign aligned   = pc_aligned(pc_q[1:0]);
  assign req_fire  = (state_q == S_REQ) && aligned && bus.arready_i;
  assign beat_fire = (state_q == S_RESP) && bus.rvalid_i;
  assign out_fire  = (state_q == S_OUT) && bus.ready_i;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_REQ;
    end else begin
      case (state_q)
        S_REQ: begin
          if (bus.redirect_i) begin
            // Request was already accepted at the old PC: go drain its beat.
            state_q <= req_fire ? S_RESP : S_REQ;
          end else if (!aligned) begin
            state_q <= S_OUT;
          end else if (bus.arready_i) begin
            state_q <= S_RESP;
          end
        end
        S_RESP: begin
          if (beat_fire) begin
            state_q <= (bus.redirect_i || flush_q) ? S_REQ : S_OUT;
          end
        end
        S_OUT: begin
          if (bus.redirect_i || bus.ready_i) begin
            state_q <= S_REQ;
          end
        end
        default: state_q <= S_REQ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else if (bus.redirect_i) begin
      pc_q <= bus.redirect_pc_i;
    end else if (out_fire) begin
      pc_q <= pc_q + IFU_PC_STEP;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      inst_q <= '0;
      err_q  <= 1'b0;
    end else if (bus.redirect_i) begin
      err_q <= 1'b0;
    end else if ((state_q == S_REQ) && !aligned) begin
      inst_q <= '0;
      err_q  <= 1'b1;
    end else if (beat_fire && !flush_q) begin
      inst_q <= bus.rdata_i;
    end else if (out_fire) begin
      err_q <= 1'b0;
    end
  end

  // flush_q marks the single outstanding beat as wrong-path.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      flush_q <= 1'b0;
    end else if (bus.redirect_i && req_fire) begin
      flush_q <= 1'b1;
    end else if (state_q == S_RESP) begin
      if (beat_fire) begin
        flush_q <= 1'b0;
      end else if (bus.redirect_i) begin
        flush_q <= 1'b1;
      end
    end
  end

  // Outputs decode registered state only; held low while reset is asserted.
  assign bus.arvalid_o = !reset && (state_q == S_REQ) && aligned;
  assign bus.araddr_o  = bus.arvalid_o ? pc_q : 32'd0;
  assign bus.rready_o  = !reset && (state_q == S_RESP);
  assign bus.valid_o   = !reset && (state_q == S_OUT);
  assign bus.pc_o      = bus.valid_o ? pc_q : 32'd0;
  assign bus.inst_o    = bus.valid_o ? inst_q : 32'd0;
  assign bus.err_o     = bus.valid_o && err_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: plays icache and decode, scoreboards delivered
// instructions against expectations queued when each fetch is driven.
module tb_ifu_fetch;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        err;
  } exp_t;

  logic clock;
  logic reset;
  ifu_fetch_if bus();

  ifu_fetch #(.RESET_PC(32'h3000_0000)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  exp_t        sb[$];
  int          checks = 0;
  int          passes = 0;
  int          fails  = 0;
  logic [31:0] exp_pc;

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_arvalid();
    int n = 0;
    while (bus.arvalid_o !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("arvalid_timeout", {31'd0, bus.arvalid_o}, 32'd1);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (bus.valid_o !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("valid_timeout", {31'd0, bus.valid_o}, 32'd1);
  endtask

  // Icache side of one fetch: optional AR stall, then a one-cycle R beat.
  task automatic fetch(input logic [31:0] data, input int ar_wait);
    wait_arvalid();
    chk("araddr", bus.araddr_o, exp_pc);
    for (int i = 0; i < ar_wait; i++) begin
      tick();
      chk("ar_hold_valid", {31'd0, bus.arvalid_o}, 32'd1);
      chk("ar_hold_addr", bus.araddr_o, exp_pc);
      chk("ar_hold_rready", {31'd0, bus.rready_o}, 32'd0);
    end
    bus.arready_i = 1'b1;
    sb.push_back('{pc: exp_pc, inst: data, err: 1'b0});
    tick();
    bus.arready_i = 1'b0;
    chk("rready", {31'd0, bus.rready_o}, 32'd1);
    bus.rvalid_i = 1'b1;
    bus.rdata_i  = data;
    tick();
    bus.rvalid_i = 1'b0;
    bus.rdata_i  = 32'd0;
  endtask

  // Decode side: hold off 'stall' cycles, then compare against the scoreboard and accept.
  task automatic deliver(input int stall);
    exp_t e;
    wait_valid();
    for (int i = 0; i < stall; i++) begin
      tick();
      chk("stall_valid", {31'd0, bus.valid_o}, 32'd1);
      chk("stall_no_ar", {31'd0, bus.arvalid_o}, 32'd0);
    end
    e = sb.pop_front();
    chk("pc_o", bus.pc_o, e.pc);
    chk("inst_o", bus.inst_o, e.inst);
    chk("err_o", {31'd0, bus.err_o}, {31'd0, e.err});
    $display("deliver pc=%h inst=%h err=%0d", bus.pc_o, bus.inst_o, bus.err_o);
    bus.ready_i = 1'b1;
    tick();
    bus.ready_i = 1'b0;
    chk("valid_drop", {31'd0, bus.valid_o}, 32'd0);
    exp_pc = exp_pc + 32'd4;
  endtask

  initial begin
    exp_t held;
    reset             = 1'b1;
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = 32'd0;
    bus.arready_i     = 1'b0;
    bus.rvalid_i      = 1'b0;
    bus.rdata_i       = 32'd0;
    bus.ready_i       = 1'b0;
    exp_pc            = 32'h3000_0000;

    // Reset state
    tick();
    #1;
    chk("rst_arvalid", {31'd0, bus.arvalid_o}, 32'd0);
    chk("rst_rready", {31'd0, bus.rready_o}, 32'd0);
    chk("rst_valid", {31'd0, bus.valid_o}, 32'd0);
    reset = 1'b0;
    #1;
    chk("rel_arvalid", {31'd0, bus.arvalid_o}, 32'd1);
    chk("rel_araddr", bus.araddr_o, 32'h3000_0000);

    // 1: first fetch and delivery, PC advances by 4
    fetch(32'h0000_0413, 0);
    deliver(0);
    chk("next_araddr", bus.araddr_o, 32'h3000_0004);

    // 2: AR held off for 5 cycles
    fetch(32'h0010_0093, 5);
    deliver(0);

    // 3: redirect in S_RESP, late beat discarded
    wait_arvalid();
    chk("t3_araddr", bus.araddr_o, exp_pc);
    bus.arready_i = 1'b1;
    tick();
    bus.arready_i     = 1'b0;
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'h8000_0000;
    tick();
    bus.redirect_i = 1'b0;
    chk("t3_rready", {31'd0, bus.rready_o}, 32'd1);
    chk("t3_no_valid", {31'd0, bus.valid_o}, 32'd0);
    bus.rvalid_i = 1'b1;
    bus.rdata_i  = 32'hDEAD_BEEF;
    tick();
    bus.rvalid_i = 1'b0;
    chk("t3_no_valid2", {31'd0, bus.valid_o}, 32'd0);
    chk("t3_arvalid", {31'd0, bus.arvalid_o}, 32'd1);
    chk("t3_araddr_new", bus.araddr_o, 32'h8000_0000);
    exp_pc = 32'h8000_0000;
    fetch(32'h0020_0113, 0);
    deliver(0);

    // 4: held output dropped by redirect even with ready_i=1
    fetch(32'h0030_0193, 0);
    wait_valid();
    held = sb.pop_front();
    chk("t4_pc_o", bus.pc_o, held.pc);
    chk("t4_inst_o", bus.inst_o, held.inst);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_hold_valid", {31'd0, bus.valid_o}, 32'd1);
      chk("t4_no_ar", {31'd0, bus.arvalid_o}, 32'd0);
    end
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'h8000_0100;
    bus.ready_i       = 1'b1;
    tick();
    bus.redirect_i = 1'b0;
    bus.ready_i    = 1'b0;
    $display("redirect in S_OUT to %h", 32'h8000_0100);
    chk("t4_dropped", {31'd0, bus.valid_o}, 32'd0);
    chk("t4_araddr", bus.araddr_o, 32'h8000_0100);

    // Redirect together with arready: old request drained, new PC requested
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'h8000_0200;
    bus.arready_i     = 1'b1;
    tick();
    bus.redirect_i = 1'b0;
    bus.arready_i  = 1'b0;
    chk("t4b_rready", {31'd0, bus.rready_o}, 32'd1);
    bus.rvalid_i = 1'b1;
    bus.rdata_i  = 32'hBAD0_BAD0;
    tick();
    bus.rvalid_i = 1'b0;
    chk("t4b_no_valid", {31'd0, bus.valid_o}, 32'd0);
    chk("t4b_araddr", bus.araddr_o, 32'h8000_0200);

    // 5: misaligned redirect target faults without a request
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'h8000_0002;
    tick();
    bus.redirect_i = 1'b0;
    chk("t5_no_ar", {31'd0, bus.arvalid_o}, 32'd0);
    chk("t5_araddr0", bus.araddr_o, 32'd0);
    exp_pc = 32'h8000_0002;
    sb.push_back('{pc: 32'h8000_0002, inst: 32'd0, err: 1'b1});
    deliver(1);
    chk("t5_no_ar2", {31'd0, bus.arvalid_o}, 32'd0);

    // 6: PC wraps from FFFF_FFFC to 0
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'hFFFF_FFFC;
    tick();
    bus.redirect_i = 1'b0;
    exp_pc = 32'hFFFF_FFFC;
    fetch(32'h1234_5678, 0);
    deliver(0);
    chk("t6_wrap_arvalid", {31'd0, bus.arvalid_o}, 32'd1);
    chk("t6_wrap_araddr", bus.araddr_o, 32'd0);

    // Reset in the middle of S_RESP
    bus.arready_i = 1'b1;
    tick();
    bus.arready_i = 1'b0;
    chk("t6_rready", {31'd0, bus.rready_o}, 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_arvalid", {31'd0, bus.arvalid_o}, 32'd0);
    chk("mid_rst_rready", {31'd0, bus.rready_o}, 32'd0);
    chk("mid_rst_valid", {31'd0, bus.valid_o}, 32'd0);
    chk("mid_rst_araddr", bus.araddr_o, 32'd0);
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("post_rst_arvalid", {31'd0, bus.arvalid_o}, 32'd1);
    chk("post_rst_araddr", bus.araddr_o, 32'h3000_0000);
    chk("post_rst_rready", {31'd0, bus.rready_o}, 32'd0);
    chk("sb_empty", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
